// File: rtl/thread_register_file_if.sv
// Operand/writeback bus between the lane sequencer and one thread register file.
// The master drives the core state, decode fields and writeback sources and
// receives the registered operands; the register file is the slave.
interface thread_register_file_if;
    logic       enable;
    logic [7:0] block_id;
    logic [2:0] core_state;
    logic [3:0] decoded_rd_address;
    logic [3:0] decoded_rs_address;
    logic [3:0] decoded_rt_address;
    logic       decoded_reg_write_enable;
    logic [1:0] decoded_reg_input_mux;
    logic [7:0] decoded_immediate;
    logic [7:0] alu_out;
    logic [7:0] lsu_out;
    logic [7:0] rs;
    logic [7:0] rt;

    modport master (
        output enable,
        output block_id,
        output core_state,
        output decoded_rd_address,
        output decoded_rs_address,
        output decoded_rt_address,
        output decoded_reg_write_enable,
        output decoded_reg_input_mux,
        output decoded_immediate,
        output alu_out,
        output lsu_out,
        input  rs,
        input  rt
    );

    modport slave (
        input  enable,
        input  block_id,
        input  core_state,
        input  decoded_rd_address,
        input  decoded_rs_address,
        input  decoded_rt_address,
        input  decoded_reg_write_enable,
        input  decoded_reg_input_mux,
        input  decoded_immediate,
        input  alu_out,
        input  lsu_out,
        output rs,
        output rt
    );
endinterface

// File: rtl/thread_register_file.sv
// Per-thread register file for one SIMT lane.
// R0-R12 are writable; R13 (%blockIdx) tracks block_id every enabled cycle,
// R14 (%blockDim) and R15 (%threadIdx) are constants fixed at elaboration.
// Operands are captured in REQUEST, writeback happens in UPDATE. The two
// states never coincide, so no write-to-read bypass exists.
//
// core_state | meaning
// IDLE    000 | no block running
// FETCH   001 | instruction fetch
// DECODE  010 | instruction decode
// REQUEST 011 | capture rs/rt operands
// WAIT    100 | waiting on memory
// EXECUTE 101 | ALU evaluates
// UPDATE  110 | write back rd
// DONE    111 | block finished
module thread_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input logic                   clk,
    input logic                   reset,
    thread_register_file_if.slave bus
);

    typedef enum logic [2:0] {
        CS_IDLE    = 3'b000,
        CS_FETCH   = 3'b001,
        CS_DECODE  = 3'b010,
        CS_REQUEST = 3'b011,
        CS_WAIT    = 3'b100,
        CS_EXECUTE = 3'b101,
        CS_UPDATE  = 3'b110,
        CS_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        SRC_ARITHMETIC = 2'b00,
        SRC_MEMORY     = 2'b01,
        SRC_CONSTANT   = 2'b10,
        SRC_RESERVED   = 2'b11
    } reg_src_t;

    localparam int NUM_GP = 13;
    localparam logic [3:0] LAST_GP = 4'd12;
    localparam logic [DATA_BITS-1:0] BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_IDX = DATA_BITS'(THREAD_ID);

    core_state_t          core_state;
    reg_src_t             reg_src;
    logic [DATA_BITS-1:0] gp_regs [NUM_GP];
    logic [DATA_BITS-1:0] block_idx;
    logic [DATA_BITS-1:0] reg_view [16];
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] rs_q;
    logic [DATA_BITS-1:0] rt_q;
    logic                 capture;
    logic                 wr_fire;

    assign core_state = core_state_t'(bus.core_state);
    assign reg_src    = reg_src_t'(bus.decoded_reg_input_mux);

    assign capture = bus.enable && (core_state == CS_REQUEST);

    // Writes to the special registers and the reserved source are dropped here.
    assign wr_fire = bus.enable
                  && (core_state == CS_UPDATE)
                  && bus.decoded_reg_write_enable
                  && (bus.decoded_rd_address <= LAST_GP)
                  && (reg_src != SRC_RESERVED);

    // Writeback source select; data passes through unmodified.
    always_comb begin
        wr_data = '0;
        unique case (reg_src)
            SRC_ARITHMETIC: wr_data = bus.alu_out;
            SRC_MEMORY:     wr_data = bus.lsu_out;
            SRC_CONSTANT:   wr_data = bus.decoded_immediate;
            default:        wr_data = '0;
        endcase
    end

    // Flat 16-entry view of the architectural registers for the read ports.
    always_comb begin
        for (int i = 0; i < NUM_GP; i++) begin
            reg_view[i] = gp_regs[i];
        end
        reg_view[13] = block_idx;
        reg_view[14] = BLOCK_DIM;
        reg_view[15] = THREAD_IDX;
    end

    // General purpose registers R0-R12.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_GP; i++) begin
                gp_regs[i] <= '0;
            end
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_GP; i++) begin
                if (bus.decoded_rd_address == 4'(i)) begin
                    gp_regs[i] <= wr_data;
                end
            end
        end
    end

    // %blockIdx follows block_id on every enabled cycle, whatever the core state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            block_idx <= '0;
        end else if (bus.enable) begin
            block_idx <= bus.block_id;
        end
    end

    // Operand capture; rs/rt hold through WAIT/EXECUTE until the next REQUEST.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_q <= '0;
            rt_q <= '0;
        end else if (capture) begin
            rs_q <= reg_view[bus.decoded_rs_address];
            rt_q <= reg_view[bus.decoded_rt_address];
        end
    end

    assign bus.rs = rs_q;
    assign bus.rt = rt_q;

endmodule

// File: tb/tb_thread_register_file.sv
// Directed bench for thread_register_file: an array-based reference model
// checked against rs/rt every falling edge, plus literal expectations.
module tb_thread_register_file;
    localparam int TPB = 4;
    localparam int TID = 2;

    localparam logic [2:0] S_IDLE    = 3'b000;
    localparam logic [2:0] S_REQUEST = 3'b011;
    localparam logic [2:0] S_WAIT    = 3'b100;
    localparam logic [2:0] S_EXECUTE = 3'b101;
    localparam logic [2:0] S_UPDATE  = 3'b110;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   check_en = 1'b0;

    thread_register_file_if rf_if ();

    thread_register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(rf_if)
    );

    always #5 clk = ~clk;

    // Reference model: 16 registers, two operand latches.
    logic [7:0] m_reg [16];
    logic [7:0] m_rs;
    logic [7:0] m_rt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) m_reg[i] <= 8'h00;
            m_reg[14] <= 8'(TPB);
            m_reg[15] <= 8'(TID);
            m_rs <= 8'h00;
            m_rt <= 8'h00;
        end else if (rf_if.enable) begin
            m_reg[13] <= rf_if.block_id;
            if (rf_if.core_state == S_REQUEST) begin
                m_rs <= m_reg[rf_if.decoded_rs_address];
                m_rt <= m_reg[rf_if.decoded_rt_address];
            end
            if (rf_if.core_state == S_UPDATE && rf_if.decoded_reg_write_enable
                && rf_if.decoded_rd_address < 4'd13) begin
                case (rf_if.decoded_reg_input_mux)
                    2'b00: m_reg[rf_if.decoded_rd_address] <= rf_if.alu_out;
                    2'b01: m_reg[rf_if.decoded_rd_address] <= rf_if.lsu_out;
                    2'b10: m_reg[rf_if.decoded_rd_address] <= rf_if.decoded_immediate;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_rs", rf_if.rs, m_rs);
            chk("cycle_rt", rf_if.rt, m_rt);
        end
    end

    task automatic tick(input logic [2:0] st);
        rf_if.core_state = st;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] rd, input logic [1:0] mux,
                             input logic [7:0] d, input logic we = 1'b1);
        rf_if.decoded_rd_address       = rd;
        rf_if.decoded_reg_input_mux    = mux;
        rf_if.decoded_reg_write_enable = we;
        rf_if.alu_out           = (mux == 2'b00) ? d : (d ^ 8'hF0);
        rf_if.lsu_out           = (mux == 2'b01) ? d : (d ^ 8'hFF);
        rf_if.decoded_immediate = (mux == 2'b10) ? d : (d ^ 8'h0F);
        tick(S_UPDATE);
        rf_if.decoded_reg_write_enable = 1'b0;
    endtask

    task automatic read_regs(input logic [3:0] rs_a, input logic [3:0] rt_a);
        rf_if.decoded_rs_address = rs_a;
        rf_if.decoded_rt_address = rt_a;
        tick(S_REQUEST);
    endtask

    initial begin
        rf_if.enable = 1'b1;
        rf_if.block_id = 8'h00;
        rf_if.core_state = S_IDLE;
        rf_if.decoded_rd_address = 4'd0;
        rf_if.decoded_rs_address = 4'd0;
        rf_if.decoded_rt_address = 4'd0;
        rf_if.decoded_reg_write_enable = 1'b0;
        rf_if.decoded_reg_input_mux = 2'b00;
        rf_if.decoded_immediate = 8'h00;
        rf_if.alu_out = 8'h00;
        rf_if.lsu_out = 8'h00;

        #2 reset = 1'b0;
        #10;
        check_en = 1'b1;
        chk("reset_rs", rf_if.rs, 8'h00);
        chk("reset_rt", rf_if.rt, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(S_IDLE);

        // Constants after reset
        read_regs(4'd14, 4'd15);
        chk("blockdim", rf_if.rs, 8'h04);
        chk("threadidx", rf_if.rt, 8'h02);

        // Writeback source select
        write_reg(4'd3, 2'b10, 8'h2A);
        read_regs(4'd3, 4'd0);
        chk("wb_const", rf_if.rs, 8'h2A);
        chk("r0_zero", rf_if.rt, 8'h00);
        write_reg(4'd3, 2'b00, 8'h7F);
        read_regs(4'd3, 4'd3);
        chk("wb_alu_rs", rf_if.rs, 8'h7F);
        chk("wb_alu_rt_same", rf_if.rt, 8'h7F);
        write_reg(4'd3, 2'b01, 8'hC3);
        read_regs(4'd3, 4'd0);
        chk("wb_lsu", rf_if.rs, 8'hC3);

        // Special registers
        rf_if.block_id = 8'd5;
        tick(S_IDLE);
        read_regs(4'd13, 4'd14);
        chk("r13_block", rf_if.rs, 8'd5);
        chk("r14_dim", rf_if.rt, 8'd4);
        write_reg(4'd14, 2'b10, 8'h99);
        write_reg(4'd13, 2'b10, 8'h99);
        write_reg(4'd15, 2'b10, 8'h99);
        read_regs(4'd13, 4'd14);
        chk("r13_no_write", rf_if.rs, 8'd5);
        chk("r14_no_write", rf_if.rt, 8'd4);
        read_regs(4'd15, 4'd15);
        chk("r15_no_write", rf_if.rs, 8'd2);

        // Operand hold across WAIT/EXECUTE/UPDATE
        write_reg(4'd1, 2'b10, 8'h10);
        write_reg(4'd2, 2'b10, 8'h20);
        read_regs(4'd1, 4'd2);
        chk("hold_rs_rd", rf_if.rs, 8'h10);
        chk("hold_rt_rd", rf_if.rt, 8'h20);
        tick(S_WAIT);
        tick(S_EXECUTE);
        write_reg(4'd1, 2'b10, 8'h55);
        chk("hold_rs_after_wb", rf_if.rs, 8'h10);
        read_regs(4'd1, 4'd2);
        chk("raw_rs", rf_if.rs, 8'h55);
        chk("raw_rt", rf_if.rt, 8'h20);

        // Enable gating
        rf_if.block_id = 8'd2;
        tick(S_IDLE);
        rf_if.enable = 1'b0;
        rf_if.block_id = 8'd7;
        read_regs(4'd13, 4'd13);
        chk("gate_rs", rf_if.rs, 8'h55);
        chk("gate_rt", rf_if.rt, 8'h20);
        write_reg(4'd1, 2'b10, 8'hEE);
        tick(S_IDLE);
        rf_if.enable = 1'b1;
        read_regs(4'd13, 4'd1);
        chk("gate_r13_frozen", rf_if.rs, 8'd2);
        chk("gate_r1_kept", rf_if.rt, 8'h55);
        tick(S_IDLE);
        read_regs(4'd13, 4'd13);
        chk("r13_tracks", rf_if.rs, 8'd7);

        // Write suppression
        write_reg(4'd4, 2'b10, 8'h44);
        write_reg(4'd4, 2'b10, 8'h77, 1'b0);
        write_reg(4'd4, 2'b11, 8'h77);
        read_regs(4'd4, 4'd4);
        chk("supp_we0_mux3", rf_if.rs, 8'h44);

        // Reset in the middle of a pending UPDATE
        rf_if.decoded_rd_address = 4'd5;
        rf_if.decoded_reg_input_mux = 2'b10;
        rf_if.decoded_immediate = 8'hAB;
        rf_if.decoded_reg_write_enable = 1'b1;
        rf_if.core_state = S_UPDATE;
        #2 reset = 1'b0;
        #1;
        chk("async_rst_rs", rf_if.rs, 8'h00);
        chk("async_rst_rt", rf_if.rt, 8'h00);
        @(posedge clk); #1;
        rf_if.core_state = S_IDLE;
        rf_if.decoded_reg_write_enable = 1'b0;
        reset = 1'b1;
        tick(S_IDLE);
        read_regs(4'd5, 4'd3);
        chk("rst_r5", rf_if.rs, 8'h00);
        chk("rst_r3", rf_if.rt, 8'h00);
        read_regs(4'd14, 4'd15);
        chk("rst_r14", rf_if.rs, 8'd4);
        chk("rst_r15", rf_if.rt, 8'd2);
        read_regs(4'd4, 4'd13);
        chk("rst_r4", rf_if.rs, 8'h00);
        chk("rst_r13_tracks", rf_if.rt, 8'd7);
        tick(S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
